// File: rtl/photocell_conditioner.sv
// rtl/photocell_conditioner.sv - photocell sync, debounce and pass-event front end for SBqM (option: STUCK_DETECT_EN)

module photocell_channel #(
    parameter int DB_CYCLES    = 4,
    parameter int DB_W         = 3,
    parameter int STUCK_CYCLES = 200,
    parameter int STUCK_W      = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    input  logic gate_i,
    output logic level_o,
    output logic pulse_o,
    output logic reject_o,
    output logic stuck_o
);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    typedef enum logic {ST_IDLE, ST_BLOCKED} state_t;

    logic [1:0]      sync_q;
    logic            level_q, level_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            toggle;
    logic            allow_event;
    state_t          state_q;
    logic            pulse_q, reject_q;

`ifdef STUCK_DETECT_EN
    localparam logic [STUCK_W-1:0] STUCK_MAX = STUCK_W'(STUCK_CYCLES);

    logic [STUCK_W-1:0] stuck_cnt_q;
    logic               stuck_q;

    // A rise that ends a stuck blockage is an obstruction clearing, not a person
    assign allow_event = ~stuck_q;
    assign stuck_o     = stuck_q;
`else
    assign allow_event = 1'b1;
    // Stuck detection is not built; parameters stay so both builds share one interface
    assign stuck_o     = 1'b0 & (STUCK_CYCLES > 0) & (STUCK_W > 0);
`endif

    // Debounce: count consecutive mismatch cycles, flip the level on the last one
    always_comb begin
        level_d  = level_q;
        db_cnt_d = '0;
        toggle   = 1'b0;
        if (sync_q[1] != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                toggle  = 1'b1;
                level_d = ~level_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // Two-flop synchroniser and debounced level; idle state is beam unbroken
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q   <= 2'b11;
            level_q  <= 1'b1;
            db_cnt_q <= '0;
        end else begin
            sync_q   <= {sync_q[0], raw_i};
            level_q  <= level_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    // Channel FSM: a fall arms the channel, the following rise is the pass event
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            pulse_q     <= 1'b0;
            reject_q    <= 1'b0;
`ifdef STUCK_DETECT_EN
            stuck_cnt_q <= '0;
            stuck_q     <= 1'b0;
`endif
        end else begin
            pulse_q  <= 1'b0;
            reject_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (toggle) begin
                        state_q <= ST_BLOCKED;
                    end
                end
                ST_BLOCKED: begin
                    if (toggle) begin
                        state_q <= ST_IDLE;
                        if (allow_event) begin
                            if (gate_i) begin
                                reject_q <= 1'b1;
                            end else begin
                                pulse_q <= 1'b1;
                            end
                        end
`ifdef STUCK_DETECT_EN
                        stuck_cnt_q <= '0;
                        stuck_q     <= 1'b0;
                    end else if (stuck_cnt_q != STUCK_MAX) begin
                        stuck_cnt_q <= stuck_cnt_q + 1'b1;
                        if (stuck_cnt_q + 1'b1 == STUCK_MAX) begin
                            stuck_q <= 1'b1;
                        end
`endif
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign level_o  = level_q;
    assign pulse_o  = pulse_q;
    assign reject_o = reject_q;

endmodule

module photocell_conditioner #(
    parameter int DB_CYCLES    = 4,
    parameter int DB_W         = 3,
    parameter int STUCK_CYCLES = 200,
    parameter int STUCK_W      = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic a_raw,
    input  logic b_raw,
    input  logic full_flag,
    input  logic empty_flag,
    output logic a_level,
    output logic b_level,
    output logic a_pulse,
    output logic b_pulse,
    output logic a_reject,
    output logic b_reject,
    output logic a_stuck,
    output logic b_stuck
);

    // Entry sensor: an entry into a full queue is rejected
    photocell_channel #(
        .DB_CYCLES(DB_CYCLES), .DB_W(DB_W),
        .STUCK_CYCLES(STUCK_CYCLES), .STUCK_W(STUCK_W)
    ) u_chan_a (
        .clk(clk), .reset(reset), .raw_i(a_raw), .gate_i(full_flag),
        .level_o(a_level), .pulse_o(a_pulse), .reject_o(a_reject), .stuck_o(a_stuck)
    );

    // Exit sensor: an exit from an empty queue is rejected
    photocell_channel #(
        .DB_CYCLES(DB_CYCLES), .DB_W(DB_W),
        .STUCK_CYCLES(STUCK_CYCLES), .STUCK_W(STUCK_W)
    ) u_chan_b (
        .clk(clk), .reset(reset), .raw_i(b_raw), .gate_i(empty_flag),
        .level_o(b_level), .pulse_o(b_pulse), .reject_o(b_reject), .stuck_o(b_stuck)
    );

endmodule

// File: tb/tb_photocell_conditioner.sv
// tb/tb_photocell_conditioner.sv - scoreboard bench for photocell_conditioner

module tb_photocell_conditioner;

    localparam int DB  = 4;
    localparam int LAT = 2 + DB;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic a_raw = 1'b1, b_raw = 1'b1;
    logic full_flag = 1'b0, empty_flag = 1'b0;
    logic a_level, b_level, a_pulse, b_pulse, a_reject, b_reject, a_stuck, b_stuck;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int mark;

    typedef struct { int kind; int cyc; } ev_t;
    ev_t sb[$];

    photocell_conditioner #(
        .DB_CYCLES(DB), .DB_W(3), .STUCK_CYCLES(10), .STUCK_W(8)
    ) dut (
        .clk(clk), .reset(reset), .a_raw(a_raw), .b_raw(b_raw),
        .full_flag(full_flag), .empty_flag(empty_flag),
        .a_level(a_level), .b_level(b_level), .a_pulse(a_pulse), .b_pulse(b_pulse),
        .a_reject(a_reject), .b_reject(b_reject), .a_stuck(a_stuck), .b_stuck(b_stuck)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int kind, input int c);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    // kind: 0 a_pulse, 1 a_reject, 2 b_pulse, 3 b_reject
    task automatic pop(input int kind);
        ev_t e;
        check("event_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("event_kind", kind, e.kind);
            check("event_cycle", cyc, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (a_pulse)  pop(0);
            if (a_reject) pop(1);
            if (b_pulse)  pop(2);
            if (b_reject) pop(3);
`ifndef STUCK_DETECT_EN
            check("a_stuck_never", a_stuck, 0);
            check("b_stuck_never", b_stuck, 0);
`endif
        end
    end

    task automatic pass(input bit do_a, input bit do_b, input int low, input bit expect_ev);
        @(negedge clk);
        if (do_a) a_raw = 1'b0;
        if (do_b) b_raw = 1'b0;
        repeat (low) @(negedge clk);
        a_raw = 1'b1;
        b_raw = 1'b1;
        if (expect_ev) begin
            if (do_a) push(full_flag ? 1 : 0, cyc + LAT);
            if (do_b) push(empty_flag ? 3 : 2, cyc + LAT);
        end
        repeat (12) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_a_level", a_level, 1);
        check("rst_b_level", b_level, 1);
        check("rst_pulses", {a_pulse, b_pulse, a_reject, b_reject}, 0);
        check("rst_stuck", {a_stuck, b_stuck}, 0);
        reset = 1'b1;

        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_levels", {a_level, b_level}, 2'b11);
        end

        // clean pass on a with level latency
        @(negedge clk);
        a_raw = 1'b0;
        repeat (LAT - 1) @(negedge clk);
        check("a_fall_early", a_level, 1);
        @(negedge clk);
        check("a_fall_lat", a_level, 0);
        repeat (20 - LAT) @(negedge clk);
        a_raw = 1'b1;
        push(0, cyc + LAT);
        repeat (LAT - 1) @(negedge clk);
        check("a_rise_early", a_level, 0);
        @(negedge clk);
        check("a_rise_lat", a_level, 1);
        check("a_pulse_direct", a_pulse, 1);
        check("b_silent_level", b_level, 1);
        @(negedge clk);
        check("a_pulse_one_cycle", a_pulse, 0);
        repeat (10) @(negedge clk);

        // glitch shorter than debounce window
        @(negedge clk);
        b_raw = 1'b0;
        repeat (DB - 1) @(negedge clk);
        b_raw = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("b_glitch_level", b_level, 1);
        end
        pass(0, 1, DB, 1);

        // gating
        full_flag = 1'b1;
        pass(1, 0, 8, 1);
        full_flag = 1'b0;
        empty_flag = 1'b1;
        pass(0, 1, 8, 1);
        empty_flag = 1'b0;
        pass(0, 1, 8, 1);
        pass(1, 0, 9, 1);

        // simultaneous events
        pass(1, 1, 10, 1);

        // reset while blocked
        @(negedge clk);
        a_raw = 1'b0;
        repeat (10) @(negedge clk);
        check("blocked_level", a_level, 0);
        reset = 1'b0;
        a_raw = 1'b1;
        #1;
        check("async_rst_level", a_level, 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        check("post_rst_level", a_level, 1);

`ifdef STUCK_DETECT_EN
        @(negedge clk);
        a_raw = 1'b0;
        repeat (15) @(negedge clk);
        check("stuck_not_yet", a_stuck, 0);
        @(negedge clk);
        check("stuck_set", a_stuck, 1);
        repeat (14) @(negedge clk);
        a_raw = 1'b1;
        repeat (LAT - 1) @(negedge clk);
        check("stuck_hold", a_stuck, 1);
        @(negedge clk);
        check("stuck_clear", a_stuck, 0);
        check("stuck_rise_level", a_level, 1);
        repeat (10) @(negedge clk);
        pass(1, 0, 5, 1);
        check("short_block_no_stuck", a_stuck, 0);
`else
        pass(1, 0, 30, 1);
        check("long_block_no_stuck", a_stuck, 0);
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/photocell_conditioner.md
Name: photocell_conditioner

Overview:
Front-end stage feeding the smart bank queue manager (SBqM). It synchronises and debounces the raw back (entry) and front (exit) photocell inputs, which idle high with the beam unbroken. It converts each complete beam break-and-restore into a single-cycle person-passed pulse. The pulses drive SBqM's a/b inputs, gated by SBqM's full/empty flags so that impossible events never reach the counter.

Parameters:
DB_CYCLES, 4, consecutive stable cycles a synced input must hold a new value before the debounced level changes (1..2^DB_W-1)
DB_W, 3, width of each debounce counter
STUCK_CYCLES, 200, cycles of continuous blockage before a channel is flagged stuck (used only with STUCK_DETECT_EN)
STUCK_W, 8, width of each stuck counter

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
a_raw  input  1  raw back/entry photocell, 1 = beam unbroken
b_raw  input  1  raw front/exit photocell, 1 = beam unbroken
full_flag  input  1  SBqM fullFlag
empty_flag  input  1  SBqM emptyFlag
a_level  output  1  debounced back-sensor level
b_level  output  1  debounced front-sensor level
a_pulse  output  1  one-cycle entry event to SBqM a
b_pulse  output  1  one-cycle exit event to SBqM b
a_reject  output  1  one-cycle: entry event dropped because full_flag=1
b_reject  output  1  one-cycle: exit event dropped because empty_flag=1
a_stuck  output  1  back beam blocked too long
b_stuck  output  1  front beam blocked too long

Behaviour:
- Reset (reset=0, asynchronous): synchroniser FFs=1; a_level=b_level=1; debounce counters=0; a_pulse, b_pulse, a_reject, b_reject=0; a_stuck, b_stuck=0; stuck counters=0.
- The two channels are identical and independent. Channel a is described below.
- Sync: 2-FF synchroniser on a_raw gives a_sync.
- Debounce: if a_sync==a_level, the counter is cleared to 0. Otherwise the counter increments. When it would reach DB_CYCLES, a_level toggles and the counter clears, in the same edge.
- Any mismatch shorter than DB_CYCLES cycles is discarded with no level change.
- Latency: a raw change held stable shows on a_level exactly 2+DB_CYCLES rising edges after the first edge that samples it (6 at default).
- Channel FSM:
  - IDLE (a_level=1).
  - BLOCKED (a_level=0).
  - IDLE->BLOCKED on a debounced fall.
  - BLOCKED->IDLE on a debounced rise. This is the event: asserted for exactly one cycle, in the same cycle a_level becomes 1.
  - A fall alone produces no event.
- Gating, evaluated on full_flag/empty_flag in the event cycle:
  - a event: full_flag=0 gives a_pulse=1; full_flag=1 gives a_reject=1 and a_pulse=0.
  - b event: empty_flag=0 gives b_pulse=1; empty_flag=1 gives b_reject=1 and b_pulse=0.
- Simultaneous a and b events in one cycle: both pass through unmodified. Arbitration belongs to SBqM.
- Pulses are registered outputs. They are never asserted for two consecutive cycles; a minimum of 2*DB_CYCLES cycles separates two events on one channel.
- Reset mid-blockage: the channel returns to IDLE and no event is issued on the subsequent rise unless a fall is seen first.

Optional Feature:
STUCK_DETECT_EN
- Defined:
  - In BLOCKED, the stuck counter increments each cycle and saturates at STUCK_CYCLES.
  - Reaching STUCK_CYCLES sets a_stuck=1. The flag holds until the debounced rise, and clears in the cycle a_level becomes 1.
  - The rise that ends a stuck blockage is treated as an obstruction: no a_pulse and no a_reject.
  - The counter clears on leaving BLOCKED.
- Undefined: a_stuck=b_stuck=0 constantly, no stuck counters are built, and every rise yields an event regardless of blockage length.

Test Plan:
- Reset then idle: reset=0 for 3 cycles, then 1, a_raw=b_raw=1 for 50 cycles -> levels 1; all pulses, rejects and stuck flags 0 throughout.
- Clean pass, DB_CYCLES=4: a_raw=0 for 20 cycles, then 1 -> a_level falls 6 cycles after the fall; a_pulse=1 for exactly one cycle, 6 cycles after the rise; b channel silent.
- Glitch rejection: b_raw low for 3 cycles (< DB_CYCLES) -> b_level stays 1, no b_pulse. A 4-cycle low followed by a rise -> exactly one b_pulse.
- Gating: full_flag=1 during an a event -> a_reject=1, a_pulse=0. empty_flag=1 during a b event -> b_reject=1, b_pulse=0. Flags 0 -> pulses pass.
- Simultaneous and reset: identical a/b break-restore aligned -> a_pulse and b_pulse in the same cycle. Assert reset while a is BLOCKED, release with a_raw=1 -> no a_pulse.
- STUCK_DETECT_EN, STUCK_CYCLES=10: a_raw=0 for 30 cycles -> a_stuck=1 from blockage cycle 10; on restore a_stuck clears, with no a_pulse and no a_reject. A 5-cycle blockage -> a_stuck stays 0 and a normal a_pulse occurs.
